// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pattern multiplexer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package vga_pkg;

    // Pixel combine mode applied at frame boundaries.
    typedef enum logic [1:0] {
        MODE_SELECT = 2'd0,
        MODE_AND    = 2'd1,
        MODE_OR     = 2'd2,
        MODE_AUTO   = 2'd3
    } mode_t;

    localparam int MODE_W = 2;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability-counter debouncer for a switch bank.
// Latency: 2 sync cycles plus DEB_CYC stable cycles before the debounced value moves.
// Backpressure: none; the switch bank is sampled every cycle.
module sw_debounce #(
    parameter int WIDTH   = 1,
    parameter int DEB_CYC = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] raw_sw,
    output logic [WIDTH-1:0] deb_sw
);

    localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous switches into the clock domain.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_sw;
            sync_q2 <= sync_q1;
        end
    end

    // Track a candidate value; any change restarts the count, and the
    // candidate is accepted once it has held for DEB_CYC cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cand       <= '0;
            stable_cnt <= '0;
            deb_sw     <= '0;
        end else if (sync_q2 != cand) begin
            cand       <= sync_q2;
            stable_cnt <= '0;
        end else if (cand != deb_sw) begin
            if (stable_cnt == CNT_W'(DEB_CYC - 1)) begin
                deb_sw     <= cand;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/vga_pattern_mux.sv
// Selects or combines test-pattern sources per pixel; switch changes apply only at frame start.
// Latency: 1 cycle from active_i/src_rgb_i to rgb_o.
// Backpressure: none; one pixel is produced every cycle.
module vga_pattern_mux
    import vga_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int CW          = 1,
    parameter int DEB_CYC     = 500000,
    parameter int AUTO_FRAMES = 60,
    localparam int SEL_W      = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [SEL_W-1:0]        sel_sw_i,
    input  logic [1:0]              mode_sw_i,
    input  logic                    frame_start_i,
    input  logic                    active_i,
    input  logic [NUM_SRC*3*CW-1:0] src_rgb_i,
    output logic [3*CW-1:0]         rgb_o,
    output logic [SEL_W-1:0]        cur_src_o,
    output logic [1:0]              cur_mode_o
);

    localparam int PW    = 3 * CW;
    localparam int CNT_W = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;

    logic [SEL_W-1:0]  deb_sel;
    logic [MODE_W-1:0] deb_mode;
    logic [SEL_W-1:0]  sel_clamped;

    mode_t             cur_mode, nxt_mode;
    logic [SEL_W-1:0]  cur_src, nxt_src;
    logic [CNT_W-1:0]  frame_cnt, nxt_cnt;
    logic [PW-1:0]     pixel;

    sw_debounce #(.WIDTH(SEL_W), .DEB_CYC(DEB_CYC)) u_sel_deb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_sw  (sel_sw_i),
        .deb_sw  (deb_sel)
    );

    sw_debounce #(.WIDTH(MODE_W), .DEB_CYC(DEB_CYC)) u_mode_deb (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .raw_sw  (mode_sw_i),
        .deb_sw  (deb_mode)
    );

    // Out-of-range selections map onto the highest source.
    assign sel_clamped = (int'(deb_sel) >= NUM_SRC) ? SEL_W'(NUM_SRC - 1) : deb_sel;

    // Applied state only moves on frame_start_i, so a frame is never split.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cur_mode  <= MODE_SELECT;
            cur_src   <= '0;
            frame_cnt <= '0;
        end else begin
            cur_mode  <= nxt_mode;
            cur_src   <= nxt_src;
            frame_cnt <= nxt_cnt;
        end
    end

    // Next applied mode/source; debounced values are the registered ones,
    // so a coincident debouncer update is seen only at the following pulse.
    always_comb begin
        nxt_mode = cur_mode;
        nxt_src  = cur_src;
        nxt_cnt  = frame_cnt;
        if (frame_start_i) begin
            nxt_mode = mode_t'(deb_mode);
            if (mode_t'(deb_mode) == MODE_AUTO) begin
                if (cur_mode != MODE_AUTO) begin
                    nxt_src = sel_clamped;
                    nxt_cnt = '0;
                end else if (frame_cnt == CNT_W'(AUTO_FRAMES - 1)) begin
                    nxt_cnt = '0;
                    nxt_src = (cur_src == SEL_W'(NUM_SRC - 1)) ? '0 : cur_src + SEL_W'(1);
                end else begin
                    nxt_cnt = frame_cnt + CNT_W'(1);
                end
            end else begin
                nxt_src = sel_clamped;
                nxt_cnt = '0;
            end
        end
    end

    // Pixel colour from the applied mode: single source or bitwise fold of all.
    always_comb begin
        logic [PW-1:0] pix_and;
        logic [PW-1:0] pix_or;
        pix_and = '1;
        pix_or  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pix_and = pix_and & src_rgb_i[k*PW +: PW];
            pix_or  = pix_or  | src_rgb_i[k*PW +: PW];
        end
        case (cur_mode)
            MODE_AND: pixel = pix_and;
            MODE_OR:  pixel = pix_or;
            default:  pixel = src_rgb_i[int'(cur_src)*PW +: PW];
        endcase
    end

    // Registered pixel output, blanked outside the visible area.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rgb_o <= '0;
        end else begin
            rgb_o <= active_i ? pixel : '0;
        end
    end

    assign cur_src_o  = cur_src;
    assign cur_mode_o = cur_mode;

endmodule

// File: tb/tb_vga_pattern_mux.sv
module tb_vga_pattern_mux;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [1:0] sel_sw_i;
    logic [1:0] mode_sw_i;
    logic       frame_start_i;
    logic       active_i;
    logic [11:0] src_rgb_i;
    logic [2:0] rgb_o;
    logic [1:0] cur_src_o;
    logic [1:0] cur_mode_o;

    // Three-source instance for the clamp case.
    logic [1:0] sel3_sw_i;
    logic [8:0] src3_rgb_i;
    logic [2:0] rgb3_o;
    logic [1:0] cur_src3_o;
    logic [1:0] cur_mode3_o;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    vga_pattern_mux #(.NUM_SRC(4), .CW(1), .DEB_CYC(4), .AUTO_FRAMES(2)) u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sel_sw_i      (sel_sw_i),
        .mode_sw_i     (mode_sw_i),
        .frame_start_i (frame_start_i),
        .active_i      (active_i),
        .src_rgb_i     (src_rgb_i),
        .rgb_o         (rgb_o),
        .cur_src_o     (cur_src_o),
        .cur_mode_o    (cur_mode_o)
    );

    vga_pattern_mux #(.NUM_SRC(3), .CW(1), .DEB_CYC(4), .AUTO_FRAMES(2)) u_dut3 (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sel_sw_i      (sel3_sw_i),
        .mode_sw_i     (2'd0),
        .frame_start_i (frame_start_i),
        .active_i      (active_i),
        .src_rgb_i     (src3_rgb_i),
        .rgb_o         (rgb3_o),
        .cur_src_o     (cur_src3_o),
        .cur_mode_o    (cur_mode3_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
    endtask

    // Drive one pixel cycle, push its expected colour, then compare the
    // registered output one cycle later against the scoreboard head.
    task automatic pix(input string tag, input logic act, input logic [2:0] exp);
        logic [2:0] e;
        active_i = act;
        exp_q.push_back(exp);
        tick();
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {5'd0, rgb_o}, {5'd0, e});
        end
        active_i = 1'b0;
    endtask

    initial begin
        reset_i       = 1'b1;
        sel_sw_i      = 2'd0;
        sel3_sw_i     = 2'd0;
        mode_sw_i     = 2'd0;
        frame_start_i = 1'b0;
        active_i      = 1'b1;
        src_rgb_i     = {3'b110, 3'b101, 3'b011, 3'b001};
        src3_rgb_i    = {3'b010, 3'b100, 3'b001};
        ticks(2);
        chk("rst_rgb",  {5'd0, rgb_o}, 8'd0);
        chk("rst_src",  {6'd0, cur_src_o}, 8'd0);
        chk("rst_mode", {6'd0, cur_mode_o}, 8'd0);
        active_i = 1'b0;
        reset_i  = 1'b0;
        tick();

        // Select source 2.
        sel_sw_i = 2'd2;
        ticks(10);
        pulse();
        chk("sel_src", {6'd0, cur_src_o}, 8'd2);
        pix("sel_act",   1'b1, 3'b101);
        pix("sel_blank", 1'b0, 3'b000);

        // Reset asserted mid-frame clears outputs without waiting for a clock.
        active_i = 1'b1;
        tick();
        chk("pre_rst_rgb", {5'd0, rgb_o}, 8'd5);
        #2 reset_i = 1'b1;
        #1;
        chk("mid_rst_rgb",  {5'd0, rgb_o}, 8'd0);
        chk("mid_rst_src",  {6'd0, cur_src_o}, 8'd0);
        chk("mid_rst_mode", {6'd0, cur_mode_o}, 8'd0);
        tick();
        reset_i  = 1'b0;
        active_i = 1'b0;
        ticks(10);
        chk("post_rst_hold", {6'd0, cur_src_o}, 8'd0);
        pulse();
        chk("post_rst_resume", {6'd0, cur_src_o}, 8'd2);

        // Bouncing switch never settles; early pulses keep source 0.
        sel_sw_i = 2'd0;
        ticks(10);
        pulse();
        chk("bounce_base", {6'd0, cur_src_o}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            sel_sw_i = (i % 2 == 0) ? 2'd1 : 2'd0;
            ticks(2);
        end
        pulse();
        chk("bounce_during", {6'd0, cur_src_o}, 8'd0);
        sel_sw_i = 2'd1;
        tick();
        pulse();
        chk("bounce_early", {6'd0, cur_src_o}, 8'd0);
        ticks(10);
        chk("bounce_no_pulse", {6'd0, cur_src_o}, 8'd0);
        pulse();
        chk("bounce_settled", {6'd0, cur_src_o}, 8'd1);

        // AND / OR of all sources.
        src_rgb_i = {3'b110, 3'b100, 3'b101, 3'b111};
        mode_sw_i = 2'd1;
        ticks(10);
        pulse();
        chk("and_mode", {6'd0, cur_mode_o}, 8'd1);
        pix("and_pix", 1'b1, 3'b100);
        mode_sw_i = 2'd2;
        ticks(10);
        pix("and_hold", 1'b1, 3'b100);
        pulse();
        chk("or_mode", {6'd0, cur_mode_o}, 8'd2);
        pix("or_pix", 1'b1, 3'b111);

        // Auto cycling with wrap, switch changes ignored while in AUTO.
        sel_sw_i  = 2'd3;
        mode_sw_i = 2'd3;
        ticks(10);
        pulse();
        chk("auto_mode",  {6'd0, cur_mode_o}, 8'd3);
        chk("auto_entry", {6'd0, cur_src_o}, 8'd3);
        pix("auto_pix", 1'b1, 3'b110);
        pulse();
        chk("auto_one_frame", {6'd0, cur_src_o}, 8'd3);
        pulse();
        chk("auto_wrap", {6'd0, cur_src_o}, 8'd0);
        sel_sw_i = 2'd0;
        ticks(10);
        pulse();
        pulse();
        chk("auto_ignore_sel", {6'd0, cur_src_o}, 8'd1);
        sel_sw_i  = 2'd2;
        mode_sw_i = 2'd0;
        ticks(10);
        chk("auto_exit_wait", {6'd0, cur_src_o}, 8'd1);
        pulse();
        chk("auto_exit_src",  {6'd0, cur_src_o}, 8'd2);
        chk("auto_exit_mode", {6'd0, cur_mode_o}, 8'd0);

        // Clamp on the three-source instance.
        sel3_sw_i = 2'd3;
        ticks(10);
        pulse();
        chk("clamp_src", {6'd0, cur_src3_o}, 8'd2);
        active_i = 1'b1;
        tick();
        chk("clamp_pix", {5'd0, rgb3_o}, 8'd2);
        active_i = 1'b0;

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
